// File: rtl/uart_rx_buffered.sv
// UART receiver (8N1) feeding a first-word-fall-through byte FIFO with valid/ready output.
// Define UART_RX_PARITY_EN for 8E1 frames; a parity mismatch is reported through frame_err.
module uart_rx_buffered #(
  parameter int CLK_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UART_RX,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       overrun,
  output logic       frame_err
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam int PW    = FIFO_DEPTH_LOG + 1;
  localparam int TW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [TW-1:0] T_HALF = TW'(CLK_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLK_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4, S_BREAK = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4, S_BREAK = 3'd5
  } state_t;
`endif

  function automatic logic parity_bad(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  state_t          state_r;
  logic            rx_meta_r, rx_s_r;
  logic [TW-1:0]   timer_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shift_r;
`ifdef UART_RX_PARITY_EN
  logic            par_r;
`endif
  logic [7:0]      mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [7:0]      data_r;
  logic            valid_r, overrun_r, frame_err_r;

  logic            stop_sample_s, frame_bad_s, push_s, pop_s, full_s, wr_en_s;
  logic [PW-1:0]   wr_ptr_nx_s, rd_ptr_nx_s;

  assign data      = data_r;
  assign valid     = valid_r;
  assign overrun   = overrun_r;
  assign frame_err = frame_err_r;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta_r <= 1'b1;
      rx_s_r    <= 1'b1;
    end else begin
      rx_meta_r <= UART_RX;
      rx_s_r    <= rx_meta_r;
    end
  end

  // Stop-sample decision and FIFO pointer arithmetic.
  always_comb begin
    stop_sample_s = (state_r == S_STOP) && (timer_r == T_LAST);
`ifdef UART_RX_PARITY_EN
    frame_bad_s   = !rx_s_r || parity_bad(shift_r, par_r);
`else
    frame_bad_s   = !rx_s_r;
`endif
    push_s        = stop_sample_s && !frame_bad_s;
    pop_s         = valid_r && ready;
    full_s        = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                    (wr_ptr_r[PW-2:0] == rd_ptr_r[PW-2:0]);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    wr_en_s       = push_s && (!full_s || pop_s);
    wr_ptr_nx_s   = wr_en_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
    rd_ptr_nx_s   = pop_s   ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
  end

  // Receive FSM: bit timer restarts on every state entry; IDLE re-entered at mid stop bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= S_IDLE;
      timer_r   <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          timer_r <= '0;
          if (!rx_s_r) state_r <= S_START;
        end
        S_START: begin
          if (timer_r == T_HALF) begin
            timer_r   <= '0;
            bit_idx_r <= 3'd0;
            state_r   <= rx_s_r ? S_IDLE : S_DATA;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        S_DATA: begin
          if (timer_r == T_LAST) begin
            timer_r <= '0;
            shift_r <= {rx_s_r, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_r <= S_PARITY;
`else
              state_r <= S_STOP;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (timer_r == T_LAST) begin
            timer_r <= '0;
            par_r   <= rx_s_r;
            state_r <= S_STOP;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
`endif
        S_STOP: begin
          if (timer_r == T_LAST) begin
            timer_r <= '0;
            state_r <= rx_s_r ? S_IDLE : S_BREAK;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        S_BREAK: begin
          timer_r <= '0;
          if (rx_s_r) state_r <= S_IDLE;
        end
        default: begin
          timer_r <= '0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO storage, pointers and registered head/flag outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 8'h00;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      data_r      <= 8'h00;
      valid_r     <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (wr_en_s) mem_r[wr_ptr_r[PW-2:0]] <= shift_r;
      wr_ptr_r    <= wr_ptr_nx_s;
      rd_ptr_r    <= rd_ptr_nx_s;
      valid_r     <= (wr_ptr_nx_s != rd_ptr_nx_s);
      // The new head may be the slot being written this very cycle.
      data_r      <= (wr_en_s && (rd_ptr_nx_s == wr_ptr_r)) ? shift_r : mem_r[rd_ptr_nx_s[PW-2:0]];
      overrun_r   <= push_s && full_s && !pop_s;
      frame_err_r <= stop_sample_s && frame_bad_s;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed self-checking bench for uart_rx_buffered (CLK_PER_BIT=16, depth 4).
module tb_uart_rx_buffered;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_EDGE = 171;
`else
  localparam int STOP_EDGE = 155;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       UART_RX = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       ready = 1'b0;
  logic       overrun;
  logic       frame_err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ovr_cnt = 0;
  int ferr_cnt = 0;

  uart_rx_buffered #(.CLK_PER_BIT(CPB), .FIFO_DEPTH_LOG(2)) dut (
    .CLK(CLK), .RST(RST), .UART_RX(UART_RX), .data(data), .valid(valid),
    .ready(ready), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (overrun === 1'b1) ovr_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
  end

  task automatic send_bits(input logic [7:0] b, input logic par, input logic stop_bit);
    @(negedge CLK); UART_RX = 1'b0; repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin UART_RX = b[i]; repeat (CPB) @(negedge CLK); end
`ifdef UART_RX_PARITY_EN
    UART_RX = par; repeat (CPB) @(negedge CLK);
`endif
    UART_RX = stop_bit; repeat (CPB) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bits(b, ^b, stop_bit);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    total_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else pass_cnt++;
    total_cnt++; if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data); else pass_cnt++;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_single();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(negedge CLK); repeat (STOP_EDGE - 1) @(posedge CLK); @(negedge CLK);
        total_cnt++; if (valid !== 1'b0) $display("FAIL single_early: valid=%b want 0 before stop sample", valid); else pass_cnt++;
        @(negedge CLK);
        total_cnt++; if (valid !== 1'b1) $display("FAIL single_latency: valid=%b want 1", valid); else pass_cnt++;
        total_cnt++; if (data !== 8'hA5) $display("FAIL single_data: got %h want a5", data); else pass_cnt++;
      end
    join
    repeat (5) @(negedge CLK);
    total_cnt++; if (valid !== 1'b1 || data !== 8'hA5) $display("FAIL single_hold: valid=%b data=%h want 1/a5", valid, data); else pass_cnt++;
    ready = 1'b1; @(negedge CLK); ready = 1'b0;
    total_cnt++; if (valid !== 1'b0) $display("FAIL single_pop: valid=%b want 0", valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int ov0;
    ov0 = ovr_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    repeat (4) @(negedge CLK);
    total_cnt++; if (ovr_cnt - ov0 != 1) $display("FAIL b2b_overrun: got %0d pulses want 1", ovr_cnt - ov0); else pass_cnt++;
    ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total_cnt++; if (valid !== 1'b1 || data !== 8'(i)) $display("FAIL b2b_data%0d: valid=%b data=%h want 1/%h", i, valid, data, 8'(i)); else pass_cnt++;
      @(negedge CLK);
    end
    ready = 1'b0;
    total_cnt++; if (valid !== 1'b0) $display("FAIL b2b_empty: valid=%b want 0", valid); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int ov0, fe0;
    ov0 = ovr_cnt; fe0 = ferr_cnt;
    ready = 1'b1;
    @(negedge CLK); UART_RX = 1'b0;
    repeat (4) @(negedge CLK); UART_RX = 1'b1;
    repeat (40) @(negedge CLK);
    ready = 1'b0;
    total_cnt++; if (valid !== 1'b0) $display("FAIL glitch_push: valid=%b want 0", valid); else pass_cnt++;
    total_cnt++; if (ferr_cnt != fe0 || ovr_cnt != ov0) $display("FAIL glitch_flags: ferr=%0d ovr=%0d want 0/0", ferr_cnt - fe0, ovr_cnt - ov0); else pass_cnt++;
  endtask

  task automatic test_break();
    int fe0;
    fe0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge CLK);
    UART_RX = 1'b1;
    repeat (CPB) @(negedge CLK);
    send_frame(8'h7E, 1'b1);
    repeat (4) @(negedge CLK);
    total_cnt++; if (ferr_cnt - fe0 != 1) $display("FAIL break_ferr: got %0d pulses want 1", ferr_cnt - fe0); else pass_cnt++;
    total_cnt++; if (valid !== 1'b1 || data !== 8'h7E) $display("FAIL break_next: valid=%b data=%h want 1/7e", valid, data); else pass_cnt++;
    ready = 1'b1; @(negedge CLK); ready = 1'b0;
    total_cnt++; if (valid !== 1'b0) $display("FAIL break_only_one: valid=%b want 0", valid); else pass_cnt++;
  endtask

  task automatic test_full_pop_push();
    int ov0;
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h55;
    ov0 = ovr_cnt;
    send_frame(8'h11, 1'b1); send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1); send_frame(8'h44, 1'b1);
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(negedge CLK); repeat (STOP_EDGE - 1) @(posedge CLK);
        @(negedge CLK); ready = 1'b1;
        @(negedge CLK); ready = 1'b0;
      end
    join
    repeat (4) @(negedge CLK);
    total_cnt++; if (ovr_cnt != ov0) $display("FAIL full_overrun: got %0d pulses want 0", ovr_cnt - ov0); else pass_cnt++;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (valid !== 1'b1 || data !== exp_q[i]) $display("FAIL full_data%0d: valid=%b data=%h want 1/%h", i, valid, data, exp_q[i]); else pass_cnt++;
      @(negedge CLK);
    end
    ready = 1'b0;
    total_cnt++; if (valid !== 1'b0) $display("FAIL full_count: valid=%b want 0 after 4 pops", valid); else pass_cnt++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int fe0;
    fe0 = ferr_cnt;
    send_bits(8'h03, 1'b0, 1'b1);
    repeat (4) @(negedge CLK);
    total_cnt++; if (valid !== 1'b1 || data !== 8'h03) $display("FAIL par_good: valid=%b data=%h want 1/03", valid, data); else pass_cnt++;
    send_bits(8'h03, 1'b1, 1'b1);
    repeat (4) @(negedge CLK);
    total_cnt++; if (ferr_cnt - fe0 != 1) $display("FAIL par_bad_ferr: got %0d pulses want 1", ferr_cnt - fe0); else pass_cnt++;
    ready = 1'b1; @(negedge CLK); ready = 1'b0;
    total_cnt++; if (valid !== 1'b0) $display("FAIL par_bad_dropped: valid=%b want 0", valid); else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid_frame();
    int fe0;
    send_frame(8'h5A, 1'b1);
    repeat (4) @(negedge CLK);
    total_cnt++; if (valid !== 1'b1) $display("FAIL rst_pre_valid: valid=%b want 1", valid); else pass_cnt++;
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (60) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        total_cnt++; if (valid !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) $display("FAIL rst_async: valid=%b ovr=%b ferr=%b want 0/0/0", valid, overrun, frame_err); else pass_cnt++;
      end
    join
    fe0 = ferr_cnt;
    @(negedge CLK); RST = 1'b0;
    repeat (3 * CPB) @(negedge CLK);
    total_cnt++; if (valid !== 1'b0 || ferr_cnt != fe0) $display("FAIL rst_after: valid=%b ferr=%0d want 0/0", valid, ferr_cnt - fe0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_full_pop_push();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
